regfile_hilo: RTL and testbench

- Architectural register file at the consuming end of the writeback interface. Accepts RegWriteW / WriteRegW / ResultW from the W stage and HI/LO results from the multiply path.
- Serves two combinational read ports to Decode (rs/rt) plus HI/LO read-out.
- Sits between writeback (producer) and decode (consumer). Owns all architectural GPR and HI/LO state.

---
 rtl/regfile_hilo_pkg.sv | 13 +
 rtl/regfile_hilo_rf_read_port.sv | 28 ++
 rtl/regfile_hilo.sv | 78 +++++++
 tb/tb_regfile_hilo.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_hilo_pkg.sv
// Shared constants and types for the GPR / HI-LO register file.
// Also used by writeback for link-register selection (REG_RA).
package regfile_hilo_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int ADDR_W_DEFAULT = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef logic [ADDR_W_DEFAULT-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_hilo_rf_read_port.sv
// One combinational GPR read mux: index 0 reads as zero.
// Build with REGFILE_BYPASS_EN to return a same-cycle write instead of the stored value.
module rf_read_port
  import regfile_hilo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] regs [2**ADDR_W],
`ifdef REGFILE_BYPASS_EN
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
`endif
  output logic [DATA_W-1:0] rdData
);

  always_comb begin
    rdData = regs[addr];
`ifdef REGFILE_BYPASS_EN
    if (wrEn && (wrAddr == addr)) rdData = wrData;
`endif
    // Zero check last so index 0 can never be bypassed.
    if (addr == ADDR_W'(REG_ZERO)) rdData = '0;
  end

endmodule

// File: rtl/regfile_hilo.sv
// Architectural GPR file with two read ports plus HI/LO, async active-high reset.
// Optional same-cycle write-through bypass: define REGFILE_BYPASS_EN.
module regfile_hilo
  import regfile_hilo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteW,
  input  logic [ADDR_W-1:0] WriteRegW,
  input  logic [DATA_W-1:0] ResultW,
  input  logic              HiLoWriteW,
  input  logic [DATA_W-1:0] HiW,
  input  logic [DATA_W-1:0] LoW,
  input  logic [ADDR_W-1:0] RsD,
  input  logic [ADDR_W-1:0] RtD,
  output logic [DATA_W-1:0] RD1D,
  output logic [DATA_W-1:0] RD2D,
  output logic [DATA_W-1:0] HiD,
  output logic [DATA_W-1:0] LoD
);

  logic [DATA_W-1:0] regs [2**ADDR_W];
  logic [DATA_W-1:0] hiReg;
  logic [DATA_W-1:0] loReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
      hiReg <= '0;
      loReg <= '0;
    end else begin
      if (RegWriteW && (WriteRegW != ADDR_W'(REG_ZERO))) regs[WriteRegW] <= ResultW;
      if (HiLoWriteW) begin
        hiReg <= HiW;
        loReg <= LoW;
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Bypass is gated by rst so reads stay zero while reset is held.
  logic bypassGpr;
  logic bypassHiLo;
  assign bypassGpr  = RegWriteW && !rst;
  assign bypassHiLo = HiLoWriteW && !rst;
  assign HiD = bypassHiLo ? HiW : hiReg;
  assign LoD = bypassHiLo ? LoW : loReg;
`else
  assign HiD = hiReg;
  assign LoD = loReg;
`endif

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) uReadRs (
    .addr   (RsD),
    .regs   (regs),
`ifdef REGFILE_BYPASS_EN
    .wrEn   (bypassGpr),
    .wrAddr (WriteRegW),
    .wrData (ResultW),
`endif
    .rdData (RD1D)
  );

  rf_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) uReadRt (
    .addr   (RtD),
    .regs   (regs),
`ifdef REGFILE_BYPASS_EN
    .wrEn   (bypassGpr),
    .wrAddr (WriteRegW),
    .wrData (ResultW),
`endif
    .rdData (RD2D)
  );

endmodule

// File: tb/tb_regfile_hilo.sv
// Self-checking bench for regfile_hilo: vector table, directed corner sequences, random vs. array model.
// Expectations follow REGFILE_BYPASS_EN when the bench is built with it.
module tb_regfile_hilo;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW;
  logic        HiLoWriteW;
  logic [31:0] HiW;
  logic [31:0] LoW;
  logic [4:0]  RsD;
  logic [4:0]  RtD;
  logic [31:0] RD1D;
  logic [31:0] RD2D;
  logic [31:0] HiD;
  logic [31:0] LoD;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model [32];
  logic [31:0] modelHi;
  logic [31:0] modelLo;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  regfile_hilo dut (
    .clk        (clk),
    .rst        (rst),
    .RegWriteW  (RegWriteW),
    .WriteRegW  (WriteRegW),
    .ResultW    (ResultW),
    .HiLoWriteW (HiLoWriteW),
    .HiW        (HiW),
    .LoW        (LoW),
    .RsD        (RsD),
    .RtD        (RtD),
    .RD1D       (RD1D),
    .RD2D       (RD2D),
    .HiD        (HiD),
    .LoD        (LoD)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] expRead(input logic [4:0] idx);
    if (rst) return 32'h0;
    if (idx == 5'd0) return 32'h0;
    if (BYPASS && RegWriteW && (WriteRegW == idx)) return ResultW;
    return model[idx];
  endfunction

  function automatic logic [31:0] expHi();
    if (rst) return 32'h0;
    if (BYPASS && HiLoWriteW) return HiW;
    return modelHi;
  endfunction

  function automatic logic [31:0] expLo();
    if (rst) return 32'h0;
    if (BYPASS && HiLoWriteW) return LoW;
    return modelLo;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    modelHi = 32'h0;
    modelLo = 32'h0;
  endtask

  // Advance one clock edge, applying the currently driven writes to the model.
  task automatic tick();
    logic        we, hlwe, r;
    logic [4:0]  wa;
    logic [31:0] wd, h, l;
    we = RegWriteW; wa = WriteRegW; wd = ResultW;
    hlwe = HiLoWriteW; h = HiW; l = LoW; r = rst;
    @(posedge clk);
    if (!r) begin
      if (we && wa != 5'd0) model[wa] = wd;
      if (hlwe) begin
        modelHi = h;
        modelLo = l;
      end
    end
    #1;
  endtask

  task automatic idle();
    RegWriteW = 1'b0; WriteRegW = 5'd0; ResultW = 32'h0;
    HiLoWriteW = 1'b0; HiW = 32'h0; LoW = 32'h0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd8,  32'hDEADBEEF, 5'd8,  5'd8,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd8,  32'h00000000, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 5'd4,  32'h00000055, 5'd4,  5'd0,  32'h00000000, 32'h00000000};
    vecs[3] = '{1'b1, 5'd31, 32'h00000001, 5'd31, 5'd8,  32'h00000001, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 5'd3,  32'h00000007, 5'd3,  5'd31, 32'h00000007, 32'h00000001};
    vecs[5] = '{1'b1, 5'd8,  32'hCAFEF00D, 5'd8,  5'd3,  32'hCAFEF00D, 32'h00000007};

    // Power-on reset
    rst = 1'b1;
    idle();
    RsD = 5'd5; RtD = 5'd31;
    modelReset();
    #2;
    chk("reset_rd1", RD1D, 32'h0);
    chk("reset_rd2", RD2D, 32'h0);
    chk("reset_hi", HiD, 32'h0);
    chk("reset_lo", LoD, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Table: write on one edge, read the next cycle
    for (int i = 0; i < 6; i++) begin
      RegWriteW = vecs[i].we; WriteRegW = vecs[i].wa; ResultW = vecs[i].wd;
      tick();
      idle();
      RsD = vecs[i].rs; RtD = vecs[i].rt;
      #1;
      chk($sformatf("table%0d_rd1", i), RD1D, vecs[i].exp1);
      chk($sformatf("table%0d_rd2", i), RD2D, vecs[i].exp2);
    end

    // Same-cycle RAW on reg31 (holds 0x1)
    RegWriteW = 1'b1; WriteRegW = 5'd31; ResultW = 32'hA5A5A5A5; RtD = 5'd31;
    #1;
    chk("raw_same_cycle", RD2D, BYPASS ? 32'hA5A5A5A5 : 32'h00000001);
    tick();
    idle();
    #1;
    chk("raw_next_cycle", RD2D, 32'hA5A5A5A5);

    // Zero register written with all ones: zero in the same cycle and after
    RegWriteW = 1'b1; WriteRegW = 5'd0; ResultW = 32'hFFFFFFFF; RsD = 5'd0;
    #1;
    chk("zero_same_cycle", RD1D, 32'h0);
    tick();
    idle();
    #1;
    chk("zero_after", RD1D, 32'h0);

    // HI/LO together with a GPR write
    HiLoWriteW = 1'b1; HiW = 32'h1; LoW = 32'hFFFFFFFE;
    RegWriteW = 1'b1; WriteRegW = 5'd3; ResultW = 32'h7;
    #1;
    chk("hi_same_cycle", HiD, BYPASS ? 32'h1 : 32'h0);
    tick();
    idle();
    RsD = 5'd3;
    #1;
    chk("hi_after", HiD, 32'h1);
    chk("lo_after", LoD, 32'hFFFFFFFE);
    chk("reg3_after", RD1D, 32'h7);

    // Async reset mid-cycle with a write pending on reg5
    RegWriteW = 1'b1; WriteRegW = 5'd5; ResultW = 32'h12345678;
    tick();
    RsD = 5'd5; ResultW = 32'h0BADF00D;
    #1;
    chk("pre_reset_reg5", RD1D, BYPASS ? 32'h0BADF00D : 32'h12345678);
    #1;
    rst = 1'b1;
    modelReset();
    #1;
    chk("async_reset_rd1", RD1D, 32'h0);
    chk("async_reset_hi", HiD, 32'h0);
    tick();
    chk("reset_held_write_lost", RD1D, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    chk("after_release_reg5", RD1D, 32'h0);
    tick();
    chk("after_release_reg5_edge", RD1D, 32'h0);
    RegWriteW = 1'b1; WriteRegW = 5'd5; ResultW = 32'h0000ABCD;
    tick();
    idle();
    #1;
    chk("rewrite_reg5", RD1D, 32'h0000ABCD);

    // Random traffic against the model, checked before and across each edge
    for (int n = 0; n < 400; n++) begin
      RegWriteW  = ($urandom_range(0, 3) != 0);
      WriteRegW  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      ResultW    = $urandom;
      HiLoWriteW = ($urandom_range(0, 3) == 0);
      HiW        = $urandom;
      LoW        = $urandom;
      RsD        = ($urandom_range(0, 3) == 0) ? WriteRegW : 5'($urandom_range(0, 31));
      RtD        = ($urandom_range(0, 3) == 0) ? WriteRegW : 5'($urandom_range(0, 31));
      #1;
      chk("rand_rd1", RD1D, expRead(RsD));
      chk("rand_rd2", RD2D, expRead(RtD));
      chk("rand_hi", HiD, expHi());
      chk("rand_lo", LoD, expLo());
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
